// File: rtl/decoder_pkg.sv
// decoder_pkg: shared mode encoding for the scanning one-hot decoder
package decoder_pkg;
  typedef enum logic {DEC_DIRECT = 1'b0, DEC_SCAN = 1'b1} dec_mode_e;
endpackage

// File: rtl/decoder_onehot.sv
// decoder_onehot: combinational binary-to-one-hot with range flag (sel_i -> oh_o, in_range_o)
module decoder_onehot #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic [OUT_W-1:0] oh_o,
  output logic             in_range_o
);
  for (genvar i = 0; i < OUT_W; i++) begin : g_bit
    assign oh_o[i] = sel_i == SEL_W'(i);
  end
  assign in_range_o = |oh_o;
endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder, handshaked DIRECT select or self-timed SCAN walk (clk/rst_n, e_i, mode_i, in_*, dwell_i -> out_o, idx_o, wrap_o, err_o)
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 2**SEL_W,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               e_i,
  input  dec_mode_e          mode_i,
  input  logic [SEL_W-1:0]   in_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [OUT_W-1:0]   out_o,
  output logic [SEL_W-1:0]   idx_o,
  output logic               wrap_o,
  output logic               err_o
);
  dec_mode_e          mode_q, mode_d;
  logic [SEL_W-1:0]   idx_q, idx_d, scan_idx, sel;
  logic [DWELL_W-1:0] cnt_q, cnt_d, scan_cnt;
  logic [OUT_W-1:0]   out_q, out_d, oh;
  logic               wrap_q, wrap_d, err_q, err_d, scan_wrap, in_range, accept, last;
  assign in_ready_o = e_i & (mode_i == DEC_DIRECT) & rst_n;
  assign accept     = in_valid_i & in_ready_o;
  assign last       = idx_q == SEL_W'(OUT_W - 1);
  // next scan position; entering SCAN restarts the walk at index 0
  always_comb begin
    scan_idx  = idx_q;
    scan_cnt  = cnt_q + DWELL_W'(1);
    scan_wrap = 1'b0;
    if (mode_q != DEC_SCAN) begin
      scan_idx = '0;
      scan_cnt = '0;
    end else if (cnt_q >= dwell_i) begin
      scan_cnt  = '0;
      scan_idx  = last ? '0 : idx_q + SEL_W'(1);
      scan_wrap = last;
    end
  end
  // single decoder shared by both modes: the raw select in DIRECT, the next scan index in SCAN
  assign sel = (mode_i == DEC_DIRECT) ? in_i : scan_idx;
  decoder_onehot #(.SEL_W(SEL_W), .OUT_W(OUT_W)) u_onehot (
    .sel_i     (sel),
    .oh_o      (oh),
    .in_range_o(in_range)
  );
  always_comb begin
    mode_d = mode_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (!e_i) begin
      out_d = '0;
    end else if (mode_i == DEC_DIRECT) begin
      mode_d = DEC_DIRECT;
      if (accept) begin
        out_d = oh;
        err_d = !in_range;
        idx_d = in_range ? in_i : idx_q;
      end
    end else begin
      mode_d = DEC_SCAN;
      idx_d  = scan_idx;
      cnt_d  = scan_cnt;
      out_d  = oh;
      wrap_d = scan_wrap;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= DEC_DIRECT;
      idx_q  <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end
  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;
  assign err_o  = err_q;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed checks of decoder_scan at OUT_W=6 and at default parameters
module tb_decoder_scan;
  import decoder_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       e_a, valid_a, ready_a, wrap_a, err_a;
  dec_mode_e  mode_a;
  logic [2:0] in_a, idx_a;
  logic [7:0] dwell_a;
  logic [5:0] out_a;
  logic       e_b, valid_b, ready_b, wrap_b, err_b;
  dec_mode_e  mode_b;
  logic [2:0] in_b, idx_b;
  logic [7:0] dwell_b;
  logic [7:0] out_b;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  decoder_scan #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .e_i(e_a), .mode_i(mode_a), .in_i(in_a),
    .in_valid_i(valid_a), .in_ready_o(ready_a), .dwell_i(dwell_a),
    .out_o(out_a), .idx_o(idx_a), .wrap_o(wrap_a), .err_o(err_a)
  );
  decoder_scan dut_b (
    .clk(clk), .rst_n(rst_n), .e_i(e_b), .mode_i(mode_b), .in_i(in_b),
    .in_valid_i(valid_b), .in_ready_o(ready_b), .dwell_i(dwell_b),
    .out_o(out_b), .idx_o(idx_b), .wrap_o(wrap_b), .err_o(err_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    e_a = 1'b1; mode_a = DEC_DIRECT; in_a = 3'd3; valid_a = 1'b1; dwell_a = 8'd0;
    e_b = 1'b0; mode_b = DEC_DIRECT; in_b = 3'd0; valid_b = 1'b0; dwell_b = 8'd0;
    #1;
    chk("rst_ready", ready_a, 0);
    chk("rst_out", out_a, 0);
    chk("rst_idx", idx_a, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("ready_direct", ready_a, 1);
    tick();
    chk("pre_rst_out", out_a, 6'h08);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out_a, 0);
    chk("async_rst_idx", idx_a, 0);
    chk("async_rst_ready", ready_a, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_a = 3'(i);
      tick();
      chk($sformatf("direct_out%0d", i), out_a, 32'(1) << i);
      chk($sformatf("direct_idx%0d", i), idx_a, i);
      chk("direct_err", err_a, 0);
    end
    in_a = 3'd6;
    tick();
    chk("range_out", out_a, 0);
    chk("range_err", err_a, 1);
    chk("range_idx", idx_a, 5);
    valid_a = 1'b0;
    tick();
    chk("err_pulse", err_a, 0);
    chk("hold_out", out_a, 0);
    mode_a = DEC_SCAN;
    #1;
    chk("scan_ready", ready_a, 0);
    tick();
    chk("enter_out", out_a, 6'h01);
    chk("enter_idx", idx_a, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("scan0_out%0d", k), out_a, 32'(1) << (k % 6));
      chk($sformatf("scan0_wrap%0d", k), wrap_a, k == 6);
      chk("scan0_ready", ready_a, 0);
    end
    dwell_a = 8'd2;
    tick();
    chk("dw2_a", out_a, 6'h01);
    tick();
    chk("dw2_b", out_a, 6'h01);
    tick();
    chk("dw2_step", out_a, 6'h02);
    tick();
    chk("dw2_hold", out_a, 6'h02);
    dwell_a = 8'd0;
    tick();
    chk("dwell_drop", out_a, 6'h04);
    chk("dwell_drop_idx", idx_a, 2);
    tick();
    chk("at3_out", out_a, 6'h08);
    dwell_a = 8'd2;
    e_a = 1'b0;
    tick();
    chk("dis_out", out_a, 0);
    chk("dis_idx", idx_a, 3);
    tick();
    chk("dis_out2", out_a, 0);
    chk("dis_wrap", wrap_a, 0);
    e_a = 1'b1;
    tick();
    chk("resume_out", out_a, 6'h08);
    chk("resume_idx", idx_a, 3);
    tick();
    chk("resume_hold", out_a, 6'h08);
    tick();
    chk("resume_step", out_a, 6'h10);
    mode_a = DEC_DIRECT;
    #1;
    chk("back_ready", ready_a, 1);
    tick();
    chk("back_out", out_a, 6'h10);
    chk("back_idx", idx_a, 4);
    e_b = 1'b1; in_b = 3'd7; valid_b = 1'b1;
    tick();
    chk("b_out7", out_b, 8'h80);
    chk("b_err7", err_b, 0);
    valid_b = 1'b0; mode_b = DEC_SCAN;
    tick();
    chk("b_enter", out_b, 8'h01);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("b_scan%0d", k), out_b, 32'(1) << (k % 8));
      chk($sformatf("b_wrap%0d", k), wrap_b, k == 8);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
